regfile_wr_arbiter: RTL
=======================

Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port between core writeback and a debug/loader requester (UART program loader, test harness).
- Core writeback has priority. Debug writes are buffered in a small FIFO and drained into idle core cycles.
- A starvation timer forces a debug slot by stalling the core for exactly one cycle.
- Sits between the writeback mux and the register file write inputs.

Parameters:
- DBG_DEPTH, 4, debug FIFO depth in entries; power of 2, minimum 2.
- STARVE_LIMIT, 8, consecutive cycles the FIFO head may wait before a forced slot; range 1..255.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- core_we  input  1  core writeback request this cycle.
- core_rd  input  5  core destination register.
- core_data  input  32  core writeback data.
- core_stall  output  1  core must hold the current instruction; core_we is ignored this cycle.
- dbg_valid  input  1  debug write offered.
- dbg_ready  output  1  FIFO can accept an entry; transfer occurs when dbg_valid && dbg_ready.
- dbg_rd  input  5  debug destination register.
- dbg_data  input  32  debug write data.
- dbg_count  output  $clog2(DBG_DEPTH)+1  current FIFO occupancy.
- rf_we  output  1  register-file write enable.
- rf_waddr  output  5  register-file write address.
- rf_wdata  output  32  register-file write data.

Behaviour:
- Reset values:
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - core_stall=0, dbg_ready=0 during the reset cycle, dbg_count=0.
  - FIFO flushed, state=ARB, starvation counter=0.
- Reset mid-operation: pending debug entries are discarded. No partial write is issued. rst dominates every other input.
- rf_we, rf_waddr and rf_wdata are registered. A granted request appears on rf_* exactly 1 cycle after the grant cycle.
- dbg_ready = (dbg_count < DBG_DEPTH). It is driven only from registered state. A pop in the same cycle does not raise ready.
- FIFO behaviour:
  - Push and pop in the same cycle on a non-full FIFO: count unchanged.
  - Pointers wrap modulo DBG_DEPTH.
- State ARB:
  - core_stall=0.
  - If core_we=1: grant core. Next cycle rf_we=(core_rd!=0), rf_waddr=core_rd, rf_wdata=core_data.
  - Else if FIFO not empty: grant debug head, pop, reset the starvation counter.
  - Else: rf_we=0 next cycle; rf_waddr and rf_wdata hold their previous values.
  - While FIFO not empty and the head is not granted: counter +1 per cycle, saturating.
  - When counter reaches STARVE_LIMIT: go to FORCE.
- State FORCE (exactly 1 cycle):
  - core_stall=1 (combinational from the state register).
  - Grant debug head unconditionally, pop, reset the counter, return to ARB.
  - core_we in this cycle is ignored. The core re-presents the same writeback next cycle.
- Writes to x0 from either source: the grant and pop are still consumed, but rf_we stays 0.
- Same address from both sources in one cycle: core wins in ARB; debug wins in FORCE. No merging.
- The counter is reset to 0 whenever the FIFO becomes empty.

Optional Feature:
- Macro REGARB_STATS_EN.
- Defined: adds output ports dbg_grant_cnt[15:0] and force_cnt[15:0].
  - dbg_grant_cnt increments on every debug pop; force_cnt increments on every FORCE cycle.
  - Both saturate at 16'hFFFF and reset to 0 on rst.
- Undefined: these ports and their counters do not exist. All other behaviour is identical.

Test Plan:
- Core only: core_we=1, core_rd=5, core_data=32'hDEADBEEF; FIFO empty -> next cycle rf_we=1, rf_waddr=5, rf_wdata=32'hDEADBEEF; core_stall=0 throughout.
- Opportunistic drain: push dbg (rd=3, 32'h12345678) while core_we=0 -> dbg_count=1, then 0; rf_we=1, rf_waddr=3 one cycle after the pop.
- Starvation: core_we held 1 every cycle, one dbg entry pushed -> core_stall=1 for exactly one cycle, 8 cycles after the entry becomes head. The debug write appears on rf_* the following cycle; core writes resume afterwards.
- Full FIFO: 5 pushes with core busy and DBG_DEPTH=4 -> dbg_ready=0 after the 4th accept, 5th not accepted, dbg_count=4. dbg_ready rises only the cycle after a pop.
- x0 and reset: dbg write to rd=0 -> popped, rf_we stays 0. Then rst=1 with 3 entries queued -> next cycle dbg_count=0, rf_we=0, core_stall=0, state ARB.

Source files
------------

// File: rtl/regfile_wr_arbiter_if.sv
// ----------------------------------------------------------------------------
// regfile_wr_arbiter_if
// Bundles the three traffic groups around the register-file write arbiter:
//   core writeback : core_we, core_rd, core_data -> core_stall
//   debug requester: dbg_valid, dbg_rd, dbg_data -> dbg_ready, dbg_count
//   register file  : rf_we, rf_waddr, rf_wdata
// With REGARB_STATS_EN defined it also carries dbg_grant_cnt and force_cnt.
// Modports: slave = arbiter side, master = driver/observer side.
// ----------------------------------------------------------------------------
interface regfile_wr_arbiter_if #(
    parameter int DBG_DEPTH = 4
);
    localparam int CW = $clog2(DBG_DEPTH) + 1;

    logic          core_we;
    logic [4:0]    core_rd;
    logic [31:0]   core_data;
    logic          core_stall;

    logic          dbg_valid;
    logic          dbg_ready;
    logic [4:0]    dbg_rd;
    logic [31:0]   dbg_data;
    logic [CW-1:0] dbg_count;

    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;

`ifdef REGARB_STATS_EN
    logic [15:0]   dbg_grant_cnt;
    logic [15:0]   force_cnt;
`endif

    modport slave (
        input  core_we, core_rd, core_data, dbg_valid, dbg_rd, dbg_data,
        output core_stall, dbg_ready, dbg_count, rf_we, rf_waddr, rf_wdata
`ifdef REGARB_STATS_EN
        , output dbg_grant_cnt, force_cnt
`endif
    );

    modport master (
        output core_we, core_rd, core_data, dbg_valid, dbg_rd, dbg_data,
        input  core_stall, dbg_ready, dbg_count, rf_we, rf_waddr, rf_wdata
`ifdef REGARB_STATS_EN
        , input dbg_grant_cnt, force_cnt
`endif
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wr_arbiter
// Shares the single register-file write port between core writeback (high
// priority) and a debug/loader requester. Debug writes are queued in a
// DBG_DEPTH-entry FIFO and drained into idle core cycles; if the FIFO head
// waits STARVE_LIMIT cycles the arbiter enters FORCE for one cycle, stalls
// the core and writes the debug head.
// Ports:
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : regfile_wr_arbiter_if.slave (core / debug / rf groups)
// Optional: define REGARB_STATS_EN to add saturating 16-bit counters
//   dbg_grant_cnt (debug pops) and force_cnt (FORCE cycles).
// ----------------------------------------------------------------------------
module regfile_wr_arbiter #(
    parameter int DBG_DEPTH    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wr_arbiter_if.slave   bus
);
    localparam int AW = $clog2(DBG_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {ST_ARB, ST_FORCE} state_t;

    state_t        r_state, w_state_nxt;
    logic [4:0]    r_fifo_rd   [DBG_DEPTH];
    logic [31:0]   r_fifo_data [DBG_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_starve, w_starve_nxt;

    logic w_ready, w_empty, w_push, w_pop;
    logic w_grant_core, w_grant_dbg;

    assign w_ready = (r_count < CW'(DBG_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.dbg_valid && w_ready && !rst;
    assign w_pop   = w_grant_dbg;

    // Ready comes from the registered count only, so a pop cannot raise it
    // in the same cycle; it is held low while reset is asserted.
    assign bus.dbg_ready  = w_ready && !rst;
    assign bus.dbg_count  = r_count;
    assign bus.core_stall = (r_state == ST_FORCE);

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_core = 1'b0;
        w_grant_dbg  = 1'b0;
        w_starve_nxt = r_starve;
        case (r_state)
            ST_FORCE: begin
                // core_we is ignored; the core re-presents next cycle
                w_grant_dbg = !w_empty;
                w_state_nxt = ST_ARB;
            end
            default: begin
                if (bus.core_we)   w_grant_core = 1'b1;
                else if (!w_empty) w_grant_dbg  = 1'b1;
            end
        endcase

        if (w_grant_dbg || w_empty) begin
            w_starve_nxt = 8'd0;
        end else begin
            if (r_starve != 8'hFF) w_starve_nxt = r_starve + 8'd1;
            if (r_state == ST_ARB && w_starve_nxt >= 8'(STARVE_LIMIT))
                w_state_nxt = ST_FORCE;
        end
    end

    // FIFO storage needs no reset: occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr]   <= bus.dbg_rd;
            r_fifo_data[r_wptr] <= bus.dbg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_ARB;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_starve     <= 8'd0;
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= 5'd0;
            bus.rf_wdata <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
            // pointers wrap naturally because DBG_DEPTH is a power of 2
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // x0 writes consume the grant but never assert rf_we
            if (w_grant_core) begin
                bus.rf_we    <= (bus.core_rd != 5'd0);
                bus.rf_waddr <= bus.core_rd;
                bus.rf_wdata <= bus.core_data;
            end else if (w_grant_dbg) begin
                bus.rf_we    <= (r_fifo_rd[r_rptr] != 5'd0);
                bus.rf_waddr <= r_fifo_rd[r_rptr];
                bus.rf_wdata <= r_fifo_data[r_rptr];
            end else begin
                bus.rf_we    <= 1'b0;
            end
        end
    end

`ifdef REGARB_STATS_EN
    logic [15:0] r_dbg_grant_cnt, r_force_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dbg_grant_cnt <= 16'd0;
            r_force_cnt     <= 16'd0;
        end else begin
            if (w_pop && r_dbg_grant_cnt != 16'hFFFF)
                r_dbg_grant_cnt <= r_dbg_grant_cnt + 16'd1;
            if (r_state == ST_FORCE && r_force_cnt != 16'hFFFF)
                r_force_cnt <= r_force_cnt + 16'd1;
        end
    end
    assign bus.dbg_grant_cnt = r_dbg_grant_cnt;
    assign bus.force_cnt     = r_force_cnt;
`endif

endmodule
